// File: rtl/vfifo_mc_sc.sv
// Multi-channel single-clock FIFO: NR_OF_CHANNELS independent queues sharing one
// simple dual-port RAM, each channel owning a fixed 2^ADDR_WIDTH-word region.
module vfifo_mc_sc #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int CH_WIDTH   = 2,
   localparam int NR_OF_CHANNELS = 1 << CH_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     d,
   input  logic [CH_WIDTH-1:0]       wr_ch,
   input  logic                      we,
   input  logic [CH_WIDTH-1:0]       rd_ch,
   input  logic                      re,
   output logic [DATA_WIDTH-1:0]     q,
   output logic                      q_valid,
   output logic [CH_WIDTH-1:0]       q_ch,
   output logic [NR_OF_CHANNELS-1:0] full,
   output logic [NR_OF_CHANNELS-1:0] empty,
   output logic                      ovf,
   output logic                      udf
);

   localparam int MEM_DEPTH = 1 << (CH_WIDTH + ADDR_WIDTH);
   localparam int PW        = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0]      mem_q [MEM_DEPTH];
   logic [PW-1:0]              wptr_q [NR_OF_CHANNELS];
   logic [PW-1:0]              wptr_d [NR_OF_CHANNELS];
   logic [PW-1:0]              rptr_q [NR_OF_CHANNELS];
   logic [PW-1:0]              rptr_d [NR_OF_CHANNELS];
   logic [NR_OF_CHANNELS-1:0]  full_q, full_d;
   logic [NR_OF_CHANNELS-1:0]  empty_q, empty_d;
   logic [DATA_WIDTH-1:0]      q_q, q_d;
   logic                       q_valid_q, q_valid_d;
   logic [CH_WIDTH-1:0]        q_ch_q, q_ch_d;
   logic                       ovf_q, ovf_d;
   logic                       udf_q, udf_d;
   logic                       wr_acc_s, rd_acc_s;
   logic [CH_WIDTH+ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;

   // Acceptance is judged on the registered flags only, so a same-channel
   // read never hits the slot being written this cycle.
   always_comb begin
      wr_acc_s  = we & ~full_q[wr_ch];
      rd_acc_s  = re & ~empty_q[rd_ch];
      wr_addr_s = {wr_ch, wptr_q[wr_ch][ADDR_WIDTH-1:0]};
      rd_addr_s = {rd_ch, rptr_q[rd_ch][ADDR_WIDTH-1:0]};
   end

   // Next-state for pointers, flags and the registered read port.
   always_comb begin
      q_valid_d = rd_acc_s;
      ovf_d     = we & full_q[wr_ch];
      udf_d     = re & empty_q[rd_ch];
      if (rd_acc_s) begin
         q_d    = mem_q[rd_addr_s];
         q_ch_d = rd_ch;
      end else begin
         q_d    = q_q;
         q_ch_d = q_ch_q;
      end
      for (int c = 0; c < NR_OF_CHANNELS; c++) begin
         if (wr_acc_s && (wr_ch == CH_WIDTH'(c))) begin
            wptr_d[c] = wptr_q[c] + PW'(1);
         end else begin
            wptr_d[c] = wptr_q[c];
         end
         if (rd_acc_s && (rd_ch == CH_WIDTH'(c))) begin
            rptr_d[c] = rptr_q[c] + PW'(1);
         end else begin
            rptr_d[c] = rptr_q[c];
         end
         empty_d[c] = (wptr_d[c] == rptr_d[c]);
         full_d[c]  = (wptr_d[c][ADDR_WIDTH] != rptr_d[c][ADDR_WIDTH]) &&
                      (wptr_d[c][ADDR_WIDTH-1:0] == rptr_d[c][ADDR_WIDTH-1:0]);
      end
   end

   // Shared storage; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s && !rst) begin
         mem_q[wr_addr_s] <= d;
      end
   end

   // Control state and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NR_OF_CHANNELS; c++) begin
            wptr_q[c] <= {PW{1'b0}};
            rptr_q[c] <= {PW{1'b0}};
         end
         full_q    <= {NR_OF_CHANNELS{1'b0}};
         empty_q   <= {NR_OF_CHANNELS{1'b1}};
         q_q       <= {DATA_WIDTH{1'b0}};
         q_valid_q <= 1'b0;
         q_ch_q    <= {CH_WIDTH{1'b0}};
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         for (int c = 0; c < NR_OF_CHANNELS; c++) begin
            wptr_q[c] <= wptr_d[c];
            rptr_q[c] <= rptr_d[c];
         end
         full_q    <= full_d;
         empty_q   <= empty_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
         q_ch_q    <= q_ch_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   assign q       = q_q;
   assign q_valid = q_valid_q;
   assign q_ch    = q_ch_q;
   assign full    = full_q;
   assign empty   = empty_q;
   assign ovf     = ovf_q;
   assign udf     = udf_q;

endmodule

// File: tb/tb_vfifo_mc_sc.sv
// Self-checking bench for vfifo_mc_sc: directed scenarios plus randomized
// round-robin traffic, checked against per-channel queue reference model.
module tb_vfifo_mc_sc;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int CW    = 2;
   localparam int NCH   = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] d = 32'h0;
   logic [CW-1:0] wr_ch = 2'd0;
   logic          we = 1'b0;
   logic [CW-1:0] rd_ch = 2'd0;
   logic          re = 1'b0;
   logic [DW-1:0] q;
   logic          q_valid;
   logic [CW-1:0] q_ch;
   logic [NCH-1:0] full, empty;
   logic          ovf, udf;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] mq [NCH][$];
   logic [DW-1:0] exp_q = 32'h0;
   logic [CW-1:0] exp_qch = 2'd0;

   vfifo_mc_sc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .d(d), .wr_ch(wr_ch), .we(we),
      .rd_ch(rd_ch), .re(re), .q(q), .q_valid(q_valid), .q_ch(q_ch),
      .full(full), .empty(empty), .ovf(ovf), .udf(udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of traffic: model decides acceptance from occupancy before the edge.
   task automatic step(input logic w, input logic [CW-1:0] wc, input logic [DW-1:0] wd,
                       input logic r, input logic [CW-1:0] rc);
      logic wa, ra;
      logic [NCH-1:0] ef, ee;
      @(negedge clk);
      rst = 1'b0; we = w; wr_ch = wc; d = wd; re = r; rd_ch = rc;
      wa = w && (mq[wc].size() < DEPTH);
      ra = r && (mq[rc].size() > 0);
      if (ra) begin
         exp_q   = mq[rc].pop_front();
         exp_qch = rc;
      end
      if (wa) mq[wc].push_back(wd);
      for (int c = 0; c < NCH; c++) begin
         ee[c] = (mq[c].size() == 0);
         ef[c] = (mq[c].size() == DEPTH);
      end
      @(posedge clk);
      #1;
      chk("q_valid", {31'd0, q_valid}, {31'd0, ra});
      chk("q", q, exp_q);
      if (ra) chk("q_ch", {30'd0, q_ch}, {30'd0, exp_qch});
      chk("ovf", {31'd0, ovf}, {31'd0, (w && !wa)});
      chk("udf", {31'd0, udf}, {31'd0, (r && !ra)});
      chk("full", {28'd0, full}, {28'd0, ef});
      chk("empty", {28'd0, empty}, {28'd0, ee});
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
   endtask

   // Reset with live requests, which must be ignored.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; we = 1'b1; re = 1'b1;
      wr_ch = 2'($urandom_range(0, 3)); rd_ch = 2'($urandom_range(0, 3)); d = $urandom;
      for (int c = 0; c < NCH; c++) mq[c].delete();
      exp_q = 32'h0; exp_qch = 2'd0;
      @(posedge clk);
      #1;
      chk("rst_empty", {28'd0, empty}, 32'h0000000f);
      chk("rst_full", {28'd0, full}, 32'h0);
      chk("rst_q_valid", {31'd0, q_valid}, 32'h0);
      chk("rst_q", q, 32'h0);
      chk("rst_q_ch", {30'd0, q_ch}, 32'h0);
      chk("rst_ovf", {31'd0, ovf}, 32'h0);
      chk("rst_udf", {31'd0, udf}, 32'h0);
   endtask

   initial begin
      logic w, r;
      logic [CW-1:0] wc, rc;
      int wpct, rpct;

      do_reset();

      // ch1: three writes then three reads
      step(1'b1, 2'd1, 32'h11, 1'b0, 2'd0);
      step(1'b1, 2'd1, 32'h22, 1'b0, 2'd0);
      step(1'b1, 2'd1, 32'h33, 1'b0, 2'd0);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
      idle();

      // ch2: fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd2, 32'hA000 + i, 1'b0, 2'd0);
      step(1'b1, 2'd2, 32'hDEAD, 1'b0, 2'd0);
      idle();
      for (int i = 0; i < DEPTH; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);

      // underflow on empty ch0
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
      idle();

      // same-cycle write+read on empty ch3, then read it back
      step(1'b1, 2'd3, 32'h5A5A, 1'b1, 2'd3);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);

      // same-cycle write+read on full ch0
      for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd0, 32'hB000 + i, 1'b0, 2'd0);
      step(1'b1, 2'd0, 32'hBEEF, 1'b1, 2'd0);
      step(1'b1, 2'd0, 32'hC001, 1'b1, 2'd0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);

      // randomized round-robin traffic with stalls
      for (int i = 0; i < 1000; i++) begin
         wpct = (i < 500) ? 85 : 55;
         rpct = (i < 500) ? 55 : 85;
         wc = 2'(i % 4);
         rc = 2'(3 - (i % 4));
         w = ($urandom_range(0, 99) < wpct);
         r = ($urandom_range(0, 99) < rpct);
         step(w, wc, $urandom, r, rc);
      end

      // mid-stream reset with ch1 holding 5 words
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 32'hE000 + i, 1'b0, 2'd0);
      do_reset();
      step(1'b1, 2'd1, 32'h7777, 1'b0, 2'd0);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
